// File: rtl/rotation_if.sv
// Bus bundle for the rotation disc: load/rotate controls in, sensors/direction/count out.
interface rotation_if;
   logic [31:0] a;
   logic        load;
   logic        left;
   logic        right;
   logic        sensorA;
   logic        sensorB;
   logic [1:0]  dir;
   logic [15:0] rev_count;

   modport master (
      output a, load, left, right,
      input  sensorA, sensorB, dir, rev_count
   );

   modport slave (
      input  a, load, left, right,
      output sensorA, sensorB, dir, rev_count
   );
endinterface

// File: rtl/rotation.sv
// Rotating 32-position disc with two fixed sensors and last-motion tracking.
// Optional revolution counter enabled by defining ROTATION_REV_COUNT_EN.
module rotation (
   input  logic      clk,
   input  logic      rst,
   rotation_if.slave bus
);

   typedef enum logic [1:0] {
      DIR_NONE  = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_RIGHT = 2'b10
   } dir_e;

   logic [31:0] disc_q, disc_d;
   dir_e        dir_q, dir_d;
   logic        step_left;
   logic        step_right;

   // Load wins over rotation; opposing requests cancel out to a hold.
   always_comb begin
      step_left  = !bus.load &&  bus.left && !bus.right;
      step_right = !bus.load && !bus.left &&  bus.right;
      disc_d     = disc_q;
      dir_d      = dir_q;
      if (bus.load) begin
         disc_d = bus.a;
      end else if (step_left) begin
         disc_d = {disc_q[30:0], disc_q[31]};
         dir_d  = DIR_LEFT;
      end else if (step_right) begin
         disc_d = {disc_q[0], disc_q[31:1]};
         dir_d  = DIR_RIGHT;
      end else begin
         dir_d  = DIR_NONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disc_q <= '0;
         dir_q  <= DIR_NONE;
      end else begin
         disc_q <= disc_d;
         dir_q  <= dir_d;
      end
   end

   assign bus.sensorA = disc_q[31];
   assign bus.sensorB = disc_q[30];
   assign bus.dir     = dir_q;

`ifdef ROTATION_REV_COUNT_EN
   logic [15:0] rev_q, rev_d;

   // A mark crossing the 31/0 seam is one revolution; at most one count per cycle.
   always_comb begin
      rev_d = rev_q;
      if (step_left && disc_q[31]) begin
         rev_d = rev_q + 16'd1;
      end else if (step_right && disc_q[0]) begin
         rev_d = rev_q - 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rev_q <= '0;
      end else begin
         rev_q <= rev_d;
      end
   end

   assign bus.rev_count = rev_q;
`else
   assign bus.rev_count = '0;
`endif

endmodule

// File: tb/tb_rotation.sv
// Self-checking bench for rotation: reference model plus directed literal checks.
module tb_rotation;

`ifdef ROTATION_REV_COUNT_EN
   localparam bit REV_ON = 1'b1;
`else
   localparam bit REV_ON = 1'b0;
`endif

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   rotation_if bus ();

   rotation dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: disc as a number, rotations as doubling/halving with wrap.
   logic [31:0] m_disc;
   logic [1:0]  m_dir;
   int          m_rev;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_disc <= 32'd0;
         m_dir  <= 2'd0;
         m_rev  <= 0;
      end else if (bus.load) begin
         m_disc <= bus.a;
      end else if (bus.left && !bus.right) begin
         m_disc <= (m_disc * 2) + ((m_disc >= 32'h8000_0000) ? 32'd1 : 32'd0);
         m_dir  <= 2'd1;
         if (m_disc >= 32'h8000_0000) m_rev <= m_rev + 1;
      end else if (bus.right && !bus.left) begin
         m_disc <= (m_disc / 2) + ((m_disc % 2 == 1) ? 32'h8000_0000 : 32'd0);
         m_dir  <= 2'd2;
         if (m_disc % 2 == 1) m_rev <= m_rev - 1;
      end else begin
         m_dir  <= 2'd0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rev();
      logic [15:0] r;
      r = m_rev[15:0];
      return REV_ON ? {16'd0, r} : 32'd0;
   endfunction

   always @(negedge clk) begin
      chk("model_sensorA", {31'd0, bus.sensorA}, {31'd0, m_disc[31]});
      chk("model_sensorB", {31'd0, bus.sensorB}, {31'd0, m_disc[30]});
      chk("model_dir",     {30'd0, bus.dir},     {30'd0, m_dir});
      chk("model_rev",     {16'd0, bus.rev_count}, exp_rev());
   end

   // Drive one cycle of inputs and return at the following falling edge.
   task automatic cyc(input logic ld, input logic [31:0] av, input logic l, input logic r);
      bus.load  = ld;
      bus.a     = av;
      bus.left  = l;
      bus.right = r;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_sensorA", {31'd0, bus.sensorA}, 32'd0);
      chk("rst_dir",     {30'd0, bus.dir},     32'd0);
      chk("rst_rev",     {16'd0, bus.rev_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      bus.a     = '0;
      bus.load  = 1'b0;
      bus.left  = 1'b0;
      bus.right = 1'b0;
      #1;
      chk("init_sensorA", {31'd0, bus.sensorA}, 32'd0);
      chk("init_sensorB", {31'd0, bus.sensorB}, 32'd0);
      chk("init_dir",     {30'd0, bus.dir},     32'd0);
      chk("init_rev",     {16'd0, bus.rev_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Load single mark at sensor A
      cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0);
      chk("load_sensorA", {31'd0, bus.sensorA}, 32'd1);
      chk("load_sensorB", {31'd0, bus.sensorB}, 32'd0);
      chk("load_dir",     {30'd0, bus.dir},     32'd0);
      chk("load_rev",     {16'd0, bus.rev_count}, 32'd0);

      // One left step wraps the mark to bit 0
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("left1_model",   m_disc, 32'h0000_0001);
      chk("left1_sensorA", {31'd0, bus.sensorA}, 32'd0);
      chk("left1_dir",     {30'd0, bus.dir},     32'd1);
      chk("left1_rev",     {16'd0, bus.rev_count}, REV_ON ? 32'd1 : 32'd0);

      // 31 more left steps: sensor B sees the mark at step 31, sensor A at step 32
      for (int unsigned k = 2; k <= 32; k++) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
         chk("leftN_sensorB", {31'd0, bus.sensorB}, (k == 31) ? 32'd1 : 32'd0);
         chk("leftN_sensorA", {31'd0, bus.sensorA}, (k == 32) ? 32'd1 : 32'd0);
      end
      chk("left32_model", m_disc, 32'h8000_0000);

      // Right rotation from a fresh reset
      do_reset();
      cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk("right1_model",   m_disc, 32'h4000_0000);
      chk("right1_sensorA", {31'd0, bus.sensorA}, 32'd0);
      chk("right1_sensorB", {31'd0, bus.sensorB}, 32'd1);
      chk("right1_dir",     {30'd0, bus.dir},     32'd2);
      for (int unsigned k = 2; k <= 32; k++) begin
         cyc(1'b0, 32'h0, 1'b0, 1'b1);
      end
      chk("right32_sensorA", {31'd0, bus.sensorA}, 32'd1);
      chk("right32_rev", {16'd0, bus.rev_count}, REV_ON ? 32'h0000_FFFF : 32'd0);

      // Both directions requested: hold with dir none
      for (int unsigned k = 0; k < 5; k++) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b1);
      end
      chk("both_sensorA", {31'd0, bus.sensorA}, 32'd1);
      chk("both_dir",     {30'd0, bus.dir},     32'd0);

      // Load beats rotation; dir keeps its prior value
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b1, 32'h0000_0003, 1'b1, 1'b0);
      chk("loadrot_model", m_disc, 32'h0000_0003);
      chk("loadrot_dir",   {30'd0, bus.dir}, 32'd2);
      chk("loadrot_sensorA", {31'd0, bus.sensorA}, 32'd0);

      // Multi-mark: right step with bit0 set, then left with bit31 set
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk("multi_model", m_disc, 32'h8000_0001);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b1, 32'hC000_0000, 1'b0, 1'b0);
      chk("multi_sensorB", {31'd0, bus.sensorB}, 32'd1);

      // Asynchronous reset between edges while rotating
      cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("pre_rst_sensorB", {31'd0, bus.sensorB}, 32'd1);
      chk("pre_rst_dir",     {30'd0, bus.dir},     32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_sensorA", {31'd0, bus.sensorA}, 32'd0);
      chk("async_sensorB", {31'd0, bus.sensorB}, 32'd0);
      chk("async_dir",     {30'd0, bus.dir},     32'd0);
      chk("async_rev",     {16'd0, bus.rev_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("post_rst_sensorA", {31'd0, bus.sensorA}, 32'd0);
      chk("post_rst_dir",     {30'd0, bus.dir},     32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rotation.md
ROTATION -- requirements
Module: rotation

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous reset, active-high.
REQ-003 a  input  32  disc pattern to load; one set bit = red mark, others = blank.
REQ-004 load  input  1  synchronous load of a into disc register.
REQ-005 left  input  1  rotate disc one position left per cycle.
REQ-006 right  input  1  rotate disc one position right per cycle.
REQ-007 sensorA  output  1  high when disc bit 31 is set (sensor A position).
REQ-008 sensorB  output  1  high when disc bit 30 is set (sensor B position, one step behind A).
REQ-009 dir  output  2  last effective motion: 00 none, 01 left, 10 right.
REQ-010 rev_count  output  16  signed two's-complement revolution count (see Configuration).

Function
REQ-011 Internal 32-bit disc register; sensorA/sensorB combinational from it, no extra latency.
REQ-012 Priority per cycle: load > rotate > hold.
REQ-013 load=1: disc <= a that cycle; left/right ignored; dir unchanged; rev_count unchanged.
REQ-014 left=1, right=0, load=0: disc <= {disc[30:0], disc[31]}; dir <= 01.
REQ-015 right=1, left=0, load=0: disc <= {disc[0], disc[31:1]}; dir <= 10.
REQ-016 left=right=1 or both 0 (load=0): disc holds; dir <= 00.
REQ-017 Left rotation moves mark bit31 -> bit0, so after sensorA pulse the mark reaches sensorB only after 31 more left steps; right rotation moves bit31 -> bit30, so sensorB follows sensorA by one cycle.
REQ-018 32 consecutive rotations in one direction return disc to its starting value.
REQ-019 Pattern a is loaded verbatim; all-zero or multi-mark patterns are legal, sensors reflect their bits directly.
REQ-020 Left/right X or undriven is outside contract; no recovery required.

Reset
REQ-021 rst=1 asynchronously clears disc to 0, dir to 00, rev_count to 0; sensorA=sensorB=0 immediately.
REQ-022 rst dominates load and rotation; first update after deassertion occurs on the next rising clk edge.
REQ-023 rst asserted mid-rotation discards position; no partial state retained.

Configuration
REQ-024 Macro ROTATION_REV_COUNT_EN controls the revolution counter.
REQ-025 With ROTATION_REV_COUNT_EN defined: rev_count increments by 1 on each left rotation where disc[31]=1 before the step (mark wraps 31->0), decrements by 1 on each right rotation where disc[0]=1 before the step (mark wraps 0->31); wraps modulo 2^16; both conditions on a multi-mark disc count once per cycle.
REQ-026 Without ROTATION_REV_COUNT_EN: rev_count port present, tied to 0; no counter logic; all other behaviour identical.

Verification
REQ-027 rst pulse, then load a=32'h8000_0000 -> sensorA=1, sensorB=0, dir=00, rev_count=0.
REQ-028 From 32'h8000_0000, left=1,right=0 for 1 cycle -> disc=32'h0000_0001, sensorA=0, dir=01, rev_count=1 (macro on) / 0 (macro off).
REQ-029 From 32'h8000_0000, left=1 for 32 cycles -> disc back to 32'h8000_0000, sensorA=1 after cycle 32, sensorB=1 only after cycle 31.
REQ-030 From 32'h8000_0000, right=1 for 1 cycle -> disc=32'h4000_0000, sensorA=0, sensorB=1, dir=10; then 31 more right cycles -> rev_count=-1 (16'hFFFF) with macro on.
REQ-031 left=right=1 for 5 cycles -> disc unchanged, dir=00; load=1 with left=1 and a=32'h0000_0003 -> disc=32'h0000_0003.
REQ-032 Assert rst asynchronously mid-rotation (between edges) -> disc, sensors, dir, rev_count cleared before next clk edge.
